// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: loader states,
// word geometry and the big-endian byte-lane select also used by the CPU's
// instruction-memory read path.
package imem_program_loader_pkg;

    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Byte lane k of a word in big-endian order: lane 0 is bits [31:24],
    // lane 3 is bits [7:0]. Lane k lands at byte address A+k.
    function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_program_loader_byte_serializer.sv
// Turns one 32-bit word into four consecutive registered byte writes at
// addr, addr+1, addr+2, addr+3 (big-endian). A start pulse presents byte 0 on
// the following cycle; last_o flags the cycle byte 3 is on the bus.
module imem_byte_serializer
    import imem_program_loader_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [31:0]       word_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              last_o
);

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [31:0]       word_q,  word_d;
    logic [1:0]        k_q,     k_d;

    // Next byte: load lane 0 on start, otherwise step through lanes 1..3 then stop.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        k_d     = k_q;
        if (start_i) begin
            we_d    = 1'b1;
            addr_d  = addr_i;
            wdata_d = be_lane(word_i, 2'd0);
            word_d  = word_i;
            k_d     = 2'd0;
        end else if (we_q) begin
            if (k_q == 2'd3) begin
                we_d = 1'b0;
            end else begin
                k_d     = k_q + 2'd1;
                addr_d  = addr_q + ADDR_W'(1);
                wdata_d = be_lane(word_q, k_q + 2'd1);
            end
        end
    end

    // Byte-write registers; reset drops the strobe immediately and abandons the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= RST_ADDR;
            wdata_q <= 8'h00;
            word_q  <= 32'h0;
            k_q     <= 2'd0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            k_q     <= k_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign last_o      = we_q && (k_q == 2'd3);

endmodule

// File: rtl/imem_program_loader.sv
// Program loader: accepts instruction words on a valid/ready stream, writes
// them big-endian into byte-wide instruction memory, and holds the CPU in
// reset until the word flagged last has been fully written.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] word_count
);

    // Word pointer carries one extra bit so a completely filled memory reads
    // as 2^ADDR_W rather than wrapping back to 0.
    localparam logic [ADDR_W:0]   BASE_PTR  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] MEM_BYTES = {2'b01, {ADDR_W{1'b0}}};

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   ptr_q,   ptr_d;
    logic [ADDR_W-2:0] cnt_q,   cnt_d;
    logic              last_q,  last_d;
    logic              in_ready_q, done_q, err_q, cpu_reset_q;

    logic              ser_start;
    logic              ser_last;
    logic [ADDR_W+1:0] ptr_end;
    logic              room;

    assign ptr_end = {1'b0, ptr_q} + (ADDR_W+2)'(BYTES_PER_WORD);
    assign room    = (ptr_end <= MEM_BYTES);

    // Next-state: accept or reject a word, retire it after byte 3, honour reload only when idle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        ser_start = 1'b0;
        case (state_q)
            ST_RECV: begin
                if (in_valid && in_ready_q) begin
                    if (room) begin
                        ser_start = 1'b1;
                        last_d    = in_last;
                        state_d   = ST_WRITE;
                    end else begin
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_WRITE: begin
                if (ser_last) begin
                    ptr_d   = ptr_q + (ADDR_W+1)'(BYTES_PER_WORD);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_q ? ST_DONE : ST_RECV;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_RECV;
                    ptr_d   = BASE_PTR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    // State register; status outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RECV;
            ptr_q       <= BASE_PTR;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            in_ready_q  <= (state_d == ST_RECV);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_ERROR);
            cpu_reset_q <= (state_d != ST_DONE);
        end
    end

    imem_byte_serializer #(
        .ADDR_W   (ADDR_W),
        .RST_ADDR (BASE_PTR[ADDR_W-1:0])
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .start_i     (ser_start),
        .word_i      (in_data),
        .addr_i      (ptr_q[ADDR_W-1:0]),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .last_o      (ser_last)
    );

    assign in_ready   = in_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_reset  = cpu_reset_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: the driver feeds random words and
// a high-level memory model queues the expected byte writes; a monitor pops
// and checks every write the loader presents.
module tb_imem_program_loader;

    localparam int ADDR_W = 8;
    localparam int MEM    = 256;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_last, reload;
    logic [31:0] in_data;
    logic        mem_we, cpu_reset, done, err;
    logic [7:0]  mem_addr, mem_wdata;
    logic [6:0]  word_count;

    always #5 clk = ~clk;

    imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    wr_t       exp_q[$];
    logic [7:0] dut_img [MEM];
    logic [7:0] ref_img [MEM];
    int        ref_ptr, ref_words;
    bit        ref_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every byte write must be the next one the model predicted.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr %0h data %0h, required no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("ready_while_writing", in_ready, 1'b0);
            end
            dut_img[mem_addr] <= mem_wdata;
        end
    end

    // Reference model: a word lands at the current pointer, MSB first, if it fits.
    task automatic model_accept(input logic [31:0] w);
        wr_t e;
        if (ref_ptr + 4 > MEM) begin
            ref_err = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                e.addr = 8'(ref_ptr + k);
                e.data = 8'((w >> (24 - 8 * k)) & 32'hFF);
                exp_q.push_back(e);
                ref_img[ref_ptr + k] = e.data;
            end
            ref_ptr += 4;
            ref_words++;
        end
    endtask

    task automatic model_restart();
        ref_ptr   = 0;
        ref_words = 0;
        ref_err   = 1'b0;
    endtask

    // Drive one word (after a random gap); returns at the negedge after the handshake edge.
    task automatic send_word(input logic [31:0] w, input bit last, input int gap_max, output int hs_cyc);
        int budget;
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        budget   = 0;
        while (in_ready !== 1'b1 && budget <= 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget > 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: actual in_ready %b, required 1 within 50 cycles", in_ready);
        end else begin
            model_accept(w);
        end
        hs_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_prog(input int n, input bit with_last, input int gap_max, input bit chk_rate);
        int hs, prev;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            send_word($urandom, with_last && (i == n - 1), gap_max, hs);
            if (chk_rate && i > 0) chk("throughput_cycles", hs - prev, 5);
            prev = hs;
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (done !== 1'b1 && budget <= 30) begin
            @(negedge clk);
            budget++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic chk_image(input string name);
        int mism;
        mism = 0;
        for (int a = 0; a < MEM; a++) if (dut_img[a] !== ref_img[a]) mism++;
        chk(name, mism, 0);
    endtask

    // Reload pulse; checks the idle-restart state on the following cycle.
    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        model_restart();
        chk("reload_cpu_reset", cpu_reset, 1'b1);
        chk("reload_done", done, 1'b0);
        chk("reload_err", err, 1'b0);
        chk("reload_ready", in_ready, 1'b1);
        chk("reload_count", word_count, 7'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        for (int a = 0; a < MEM; a++) begin
            dut_img[a] = 8'h00;
            ref_img[a] = 8'h00;
        end
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0;
        model_restart();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_word_count", word_count, 7'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1'b1);

        // Single word with last: four bytes back to back, done the cycle after byte 3.
        send_word(32'h3C01_1001, 1'b1, 0, hs);
        chk("t1_first_byte_we", mem_we, 1'b1);
        repeat (3) @(negedge clk);
        chk("t1_done_not_early", done, 1'b0);
        @(negedge clk);
        chk("t1_done", done, 1'b1);
        chk("t1_cpu_run", cpu_reset, 1'b0);
        chk("t1_count", word_count, 7'd1);
        // Input is ignored once done.
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (5) begin
            @(negedge clk);
            chk("done_ignores_valid", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        chk_image("t1_image");

        // 54 words streamed with valid always high: one accept every 5 cycles.
        do_reload();
        send_prog(54, 1'b1, 0, 1'b1);
        wait_done();
        chk("t2_count", word_count, 7'd54);
        chk("t2_cpu_run", cpu_reset, 1'b0);
        chk("t2_err", err, 1'b0);
        chk_image("t2_image");

        // Random gaps on valid: no dropped or duplicated words.
        do_reload();
        send_prog(40, 1'b1, 3, 1'b0);
        wait_done();
        chk("t3_count", word_count, 7'd40);
        chk_image("t3_image");

        // Reload pulsed mid-word is ignored; the load carries on.
        do_reload();
        send_prog(2, 1'b0, 1, 1'b0);
        send_word($urandom, 1'b0, 0, hs);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("t6_still_loading", cpu_reset, 1'b1);
        send_prog(3, 1'b1, 1, 1'b0);
        wait_done();
        chk("t6_count", word_count, 7'd6);
        chk_image("t6_image");

        // Last word exactly filling memory is legal.
        do_reload();
        send_prog(64, 1'b1, 0, 1'b0);
        wait_done();
        chk("fill_err", err, 1'b0);
        chk("fill_count", word_count, 7'd64);
        chk_image("fill_image");

        // Overflow: 65th word is discarded and flags an error.
        do_reload();
        send_prog(64, 1'b0, 1, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0, 0, hs);
        chk("ovf_err", err, ref_err);
        chk("ovf_no_write", mem_we, 1'b0);
        chk("ovf_cpu_reset", cpu_reset, 1'b1);
        chk("ovf_done", done, 1'b0);
        chk("ovf_ready", in_ready, 1'b0);
        chk("ovf_count", word_count, 7'd64);
        repeat (3) @(negedge clk);
        chk("ovf_err_sticky", err, 1'b1);
        do_reload();
        send_prog(3, 1'b1, 1, 1'b0);
        wait_done();
        chk("ovf_refill_count", word_count, 7'd3);
        chk_image("ovf_refill_image");

        // Reset during byte 2 of word 3: strobe drops at once, load restarts from base.
        do_reload();
        send_prog(2, 1'b0, 0, 1'b0);
        send_word($urandom, 1'b0, 0, hs);
        repeat (2) @(negedge clk);
        chk("t5_byte2_we", mem_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_we_drop", mem_we, 1'b0);
        chk("t5_cpu_reset", cpu_reset, 1'b1);
        chk("t5_count", word_count, 7'd0);
        chk("t5_addr", mem_addr, 8'h00);
        exp_q.delete();
        model_restart();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready", in_ready, 1'b1);
        send_prog(4, 1'b1, 1, 1'b0);
        wait_done();
        chk("t5_reload_count", word_count, 7'd4);
        chk_image("t5_image");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
